// File: rtl/led_panel_pkg.sv
// Shared types and helpers for the LED panel scan engine: FSM states,
// RGB bit positions inside a pixel word, and the pixel address width.
package led_panel_pkg;

   typedef enum logic [2:0] {
      LOAD, SHIFT_LO, SHIFT_HI, LATCH, UNBLANK, HOLD, NEXTROW
   } scan_state_t;

   localparam int RED_BIT   = 2;
   localparam int GREEN_BIT = 1;
   localparam int BLUE_BIT  = 0;

   // Address covers {half, row, col} for both panel halves.
   function automatic int calc_aw(input int cols, input int scan_rows);
      return $clog2(2 * cols * scan_rows);
   endfunction

endpackage

// File: rtl/led_panel_fb.sv
// Dual-bank pixel store: writes always target the back bank, and both panel
// halves of the display bank are read combinationally at the same {row, col}.
module led_panel_fb #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          disp_bank,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [2:0]    wr_data,
   input  logic [AW-2:0] rd_addr,
   output logic [2:0]    upper_data,
   output logic [2:0]    lower_data
);

   logic [2:0] mem [0:(1 << (AW + 1)) - 1];

   always_ff @(posedge clk) begin
      if (wr_en) mem[{~disp_bank, wr_addr}] <= wr_data;
   end

   assign upper_data = mem[{disp_bank, 1'b0, rd_addr}];
   assign lower_data = mem[{disp_bank, 1'b1, rd_addr}];

endmodule

// File: rtl/led_panel_scan.sv
// HUB-style LED panel scanner: shifts one row of both halves, latches it,
// holds it lit for a brightness-controlled window, then steps the row address.
module led_panel_scan import led_panel_pkg::*; #(
   parameter  int COLS        = 32,
   parameter  int SCAN_ROWS   = 4,
   parameter  int HOLD_CYCLES = 16,
   localparam int AW          = calc_aw(COLS, SCAN_ROWS),
   localparam int BW          = $clog2(HOLD_CYCLES) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [2:0]    wr_data,
   input  logic          swap_req,
   input  logic [BW-1:0] brightness_in,
   output logic          red_out,
   output logic          green_out,
   output logic          blue_out,
   output logic          sclk_out,
   output logic          latch_out,
   output logic          blank_out,
   output logic          aclk_out,
   output logic          arst_out,
   output logic          swap_ack
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(SCAN_ROWS);

   scan_state_t   state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [BW-1:0] hold_cnt;
   logic [BW-1:0] bright;
   logic          disp_bank;
   logic          pending;
   logic [2:0]    upper_px;
   logic [2:0]    lower_px;

   led_panel_fb #(.AW(AW)) u_fb (
      .clk        (clk),
      .disp_bank  (disp_bank),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr    ({row, col}),
      .upper_data (upper_px),
      .lower_data (lower_px)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= LOAD;
         col       <= '0;
         row       <= '0;
         hold_cnt  <= '0;
         bright    <= '0;
         disp_bank <= 1'b0;
         pending   <= 1'b0;
         red_out   <= 1'b0;
         green_out <= 1'b0;
         blue_out  <= 1'b0;
         sclk_out  <= 1'b1;
         latch_out <= 1'b0;
         blank_out <= 1'b1;
         aclk_out  <= 1'b0;
         arst_out  <= 1'b1;
         swap_ack  <= 1'b0;
      end else begin
         swap_ack <= 1'b0;
         if (swap_req) pending <= 1'b1;
         case (state)
            LOAD: begin
               blank_out <= 1'b1;
               latch_out <= 1'b0;
               aclk_out  <= 1'b0;
               arst_out  <= 1'b0;
               col       <= CW'(COLS - 1);
               state     <= SHIFT_LO;
            end
            SHIFT_LO: begin
               sclk_out  <= 1'b0;
               red_out   <= lower_px[RED_BIT];
               green_out <= lower_px[GREEN_BIT];
               blue_out  <= lower_px[BLUE_BIT];
               state     <= SHIFT_HI;
            end
            SHIFT_HI: begin
               sclk_out  <= 1'b1;
               red_out   <= upper_px[RED_BIT];
               green_out <= upper_px[GREEN_BIT];
               blue_out  <= upper_px[BLUE_BIT];
               col       <= col - 1'b1;
               state     <= (col == '0) ? LATCH : SHIFT_LO;
            end
            LATCH: begin
               latch_out <= 1'b1;
               state     <= UNBLANK;
            end
            UNBLANK: begin
               latch_out <= 1'b0;
               bright    <= brightness_in;
               hold_cnt  <= '0;
               blank_out <= (brightness_in == '0);
               state     <= HOLD;
            end
            HOLD: begin
               // Lit while the next hold index is still below the sampled level.
               blank_out <= (hold_cnt == BW'(HOLD_CYCLES - 1)) ||
                            !((hold_cnt + BW'(1)) < bright);
               hold_cnt  <= hold_cnt + BW'(1);
               if (hold_cnt == BW'(HOLD_CYCLES - 1)) state <= NEXTROW;
            end
            NEXTROW: begin
               blank_out <= 1'b1;
               if (row == RW'(SCAN_ROWS - 1)) begin
                  row      <= '0;
                  arst_out <= 1'b1;
                  // A request arriving in this very cycle joins this swap.
                  if (pending || swap_req) begin
                     disp_bank <= ~disp_bank;
                     swap_ack  <= 1'b1;
                     pending   <= 1'b0;
                  end
               end else begin
                  row      <= row + 1'b1;
                  aclk_out <= 1'b1;
               end
               state <= LOAD;
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_led_panel_scan.sv
// Directed bench for led_panel_scan: default geometry plus an 8x8 instance.
module tb_led_panel_scan;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [2:0] wr_data;
   logic       swap_req;
   logic [4:0] brightness_in;
   logic       red_out, green_out, blue_out, sclk_out, latch_out, blank_out;
   logic       aclk_out, arst_out, swap_ack;

   logic       sm_wr_en;
   logic [6:0] sm_wr_addr;
   logic [2:0] sm_wr_data;
   logic       sm_swap_req;
   logic       sm_red, sm_green, sm_blue, sm_sclk, sm_latch, sm_blank;
   logic       sm_aclk, sm_arst, sm_ack;

   int checks = 0;
   int errors = 0;

   led_panel_scan dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .swap_req(swap_req), .brightness_in(brightness_in),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .sclk_out(sclk_out), .latch_out(latch_out), .blank_out(blank_out),
      .aclk_out(aclk_out), .arst_out(arst_out), .swap_ack(swap_ack)
   );

   led_panel_scan #(.COLS(8), .SCAN_ROWS(8)) u_small (
      .clk(clk), .reset(reset), .wr_en(sm_wr_en), .wr_addr(sm_wr_addr), .wr_data(sm_wr_data),
      .swap_req(sm_swap_req), .brightness_in(brightness_in),
      .red_out(sm_red), .green_out(sm_green), .blue_out(sm_blue),
      .sclk_out(sm_sclk), .latch_out(sm_latch), .blank_out(sm_blank),
      .aclk_out(sm_aclk), .arst_out(sm_arst), .swap_ack(sm_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Writes every back-bank address (tgt gets d, others 0); optional swap pulses.
   task automatic fill_back(input int tgt, input logic [2:0] d, input int p1, input int p2,
                            output int acks);
      acks = 0;
      for (int a = 0; a < 256; a++) begin
         @(negedge clk);
         if (swap_ack) acks++;
         wr_en    = 1'b1;
         wr_addr  = 8'(a);
         wr_data  = (a == tgt) ? d : 3'b000;
         swap_req = (a == p1) || (a == p2);
      end
      @(negedge clk);
      if (swap_ack) acks++;
      wr_en    = 1'b0;
      swap_req = 1'b0;
   endtask

   task automatic wait_ack(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         if (swap_ack) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if ({red_out, green_out, blue_out} !== 3'b000) begin errors++; $display("FAIL reset_rgb: got %b expected 000", {red_out, green_out, blue_out}); end
      checks++; if (sclk_out !== 1'b1)  begin errors++; $display("FAIL reset_sclk: got %b expected 1", sclk_out); end
      checks++; if (latch_out !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b expected 0", latch_out); end
      checks++; if (blank_out !== 1'b1) begin errors++; $display("FAIL reset_blank: got %b expected 1", blank_out); end
      checks++; if (aclk_out !== 1'b0)  begin errors++; $display("FAIL reset_aclk: got %b expected 0", aclk_out); end
      checks++; if (arst_out !== 1'b1)  begin errors++; $display("FAIL reset_arst: got %b expected 1", arst_out); end
      checks++; if (swap_ack !== 1'b0)  begin errors++; $display("FAIL reset_ack: got %b expected 0", swap_ack); end
   endtask

   task automatic test_frame();
      int arst_n = 0, arst_last = -1, aclk_n = 0, aclk_first = -1, sclk_lo = 0;
      int latch_n = 0, latch_first = -1, latch_dbl = 0;
      int s_arst_n = 0, s_arst_last = -1, s_aclk_n = 0, s_sclk_lo = 0, s_latch_n = 0;
      logic prev_latch = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i <= 336; i++) begin
         if (i > 0) @(negedge clk);
         if (arst_out) begin arst_n++; arst_last = i; end
         if (i < 336) begin
            if (aclk_out) begin aclk_n++; if (aclk_first < 0) aclk_first = i; end
            if (!sclk_out) sclk_lo++;
            if (latch_out) begin latch_n++; if (latch_first < 0) latch_first = i; end
            if (latch_out && prev_latch) latch_dbl++;
            prev_latch = latch_out;
         end
         if (i <= 288 && sm_arst) begin s_arst_n++; s_arst_last = i; end
         if (i < 288) begin
            if (sm_aclk) s_aclk_n++;
            if (!sm_sclk) s_sclk_lo++;
            if (sm_latch) s_latch_n++;
         end
      end
      checks++; if (arst_n !== 2)      begin errors++; $display("FAIL frame_arst_count: got %0d expected 2", arst_n); end
      checks++; if (arst_last !== 336) begin errors++; $display("FAIL frame_period: got %0d expected 336", arst_last); end
      checks++; if (aclk_n !== 3)      begin errors++; $display("FAIL frame_aclk_count: got %0d expected 3", aclk_n); end
      checks++; if (aclk_first !== 84) begin errors++; $display("FAIL row_period: got %0d expected 84", aclk_first); end
      checks++; if (sclk_lo !== 128)   begin errors++; $display("FAIL sclk_pairs: got %0d expected 128", sclk_lo); end
      checks++; if (latch_n !== 4)     begin errors++; $display("FAIL latch_count: got %0d expected 4", latch_n); end
      checks++; if (latch_first !== 66) begin errors++; $display("FAIL latch_pos: got %0d expected 66", latch_first); end
      checks++; if (latch_dbl !== 0)   begin errors++; $display("FAIL latch_width: got %0d expected 0", latch_dbl); end
      checks++; if (s_arst_n !== 2)    begin errors++; $display("FAIL small_arst_count: got %0d expected 2", s_arst_n); end
      checks++; if (s_arst_last !== 288) begin errors++; $display("FAIL small_frame_period: got %0d expected 288", s_arst_last); end
      checks++; if (s_aclk_n !== 7)    begin errors++; $display("FAIL small_rows: got %0d expected 7", s_aclk_n); end
      checks++; if (s_sclk_lo !== 64)  begin errors++; $display("FAIL small_sclk_pairs: got %0d expected 64", s_sclk_lo); end
      checks++; if (s_latch_n !== 8)   begin errors++; $display("FAIL small_latch_count: got %0d expected 8", s_latch_n); end
   endtask

   task automatic test_brightness(input logic [4:0] b, input int lit);
      int low_n = 0, run = 0, max_run = 0;
      brightness_in = b;
      repeat (336) @(negedge clk);
      for (int i = 0; i < 336; i++) begin
         @(negedge clk);
         if (!blank_out) begin
            low_n++; run++;
            if (run > max_run) max_run = run;
         end else run = 0;
      end
      checks++; if (low_n !== 4 * lit) begin errors++; $display("FAIL bright_%0d_total: got %0d expected %0d", b, low_n, 4 * lit); end
      checks++; if (max_run !== lit)   begin errors++; $display("FAIL bright_%0d_run: got %0d expected %0d", b, max_run, lit); end
   endtask

   task automatic test_swap();
      int acks, red_n = 0, red_idx = -1, gb_n = 0, ack_n = 0;
      logic red_sclk = 1'b0;
      bit ok;
      // Pixel {half 0, row 1, col 5} = red.
      fill_back(37, 3'b100, 255, -1, acks);
      wait_ack(ok);
      checks++; if (!ok) begin errors++; $display("FAIL swap_ack_timeout: got none expected 1"); return; end
      checks++; if (arst_out !== 1'b1) begin errors++; $display("FAIL swap_at_frame_end: got arst %b expected 1", arst_out); end
      for (int i = 0; i < 336; i++) begin
         if (i > 0) begin
            @(negedge clk);
            if (swap_ack) ack_n++;
         end
         if (red_out) begin red_n++; red_idx = i; red_sclk = sclk_out; end
         if (green_out || blue_out) gb_n++;
      end
      checks++; if (red_n !== 1)     begin errors++; $display("FAIL swap_red_count: got %0d expected 1", red_n); end
      checks++; if (red_idx !== 139) begin errors++; $display("FAIL swap_red_pos: got %0d expected 139", red_idx); end
      checks++; if (red_sclk !== 1'b1) begin errors++; $display("FAIL swap_red_half: got sclk %b expected 1", red_sclk); end
      checks++; if (gb_n !== 0)      begin errors++; $display("FAIL swap_gb: got %0d expected 0", gb_n); end
      checks++; if (ack_n !== 0)     begin errors++; $display("FAIL swap_ack_width: got %0d expected 0", ack_n); end
   endtask

   // Entered at the frame-end interval left by test_swap.
   task automatic test_back_to_back();
      int acks, ack_n = 0, red_n = 0, red_idx = -1, grn_n = 0, grn_idx = -1;
      bit ok;
      fill_back(-1, 3'b000, 10, 100, acks);
      checks++; if (acks !== 0) begin errors++; $display("FAIL b2b_early_ack: got %0d expected 0", acks); end
      wait_ack(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_ack_timeout: got none expected 1"); return; end
      for (int i = 1; i < 335; i++) begin
         @(negedge clk);
         if (swap_ack) ack_n++;
      end
      checks++; if (ack_n !== 0) begin errors++; $display("FAIL b2b_single_swap: got %0d extra expected 0", ack_n); end
      // Frame-end cycle: request and a write to {half 1, row 0, col 0}.
      @(negedge clk);
      swap_req = 1'b1; wr_en = 1'b1; wr_addr = 8'd128; wr_data = 3'b010;
      @(negedge clk);
      swap_req = 1'b0; wr_en = 1'b0;
      checks++; if (swap_ack !== 1'b1) begin errors++; $display("FAIL coincident_swap: got %b expected 1", swap_ack); end
      ack_n = 0;
      for (int j = 0; j < 672; j++) begin
         if (j > 0) begin
            @(negedge clk);
            if (swap_ack) ack_n++;
         end
         if (j < 336) begin
            if (red_out)   begin red_n++; red_idx = j; end
            if (green_out) begin grn_n++; grn_idx = j; end
         end
      end
      checks++; if (ack_n !== 0)     begin errors++; $display("FAIL coincident_no_repeat: got %0d expected 0", ack_n); end
      checks++; if (grn_n !== 1)     begin errors++; $display("FAIL coincident_write_count: got %0d expected 1", grn_n); end
      checks++; if (grn_idx !== 64)  begin errors++; $display("FAIL coincident_write_pos: got %0d expected 64", grn_idx); end
      checks++; if (red_n !== 1)     begin errors++; $display("FAIL bank_keep_red: got %0d expected 1", red_n); end
      checks++; if (red_idx !== 139) begin errors++; $display("FAIL bank_keep_red_pos: got %0d expected 139", red_idx); end
   endtask

   task automatic test_reset_mid();
      int early_aclk = 0;
      brightness_in = 5'd16;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (238) @(negedge clk);
      checks++; if (blank_out !== 1'b0) begin errors++; $display("FAIL pre_reset_blank: got %b expected 0", blank_out); end
      #2 reset = 1'b1;
      #1;
      checks++; if (blank_out !== 1'b1) begin errors++; $display("FAIL async_blank: got %b expected 1", blank_out); end
      checks++; if (arst_out !== 1'b1)  begin errors++; $display("FAIL async_arst: got %b expected 1", arst_out); end
      checks++; if ({sclk_out, latch_out, aclk_out} !== 3'b100) begin errors++; $display("FAIL async_ctrl: got %b expected 100", {sclk_out, latch_out, aclk_out}); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i <= 84; i++) begin
         if (i > 0) @(negedge clk);
         if (i < 84 && aclk_out) early_aclk++;
         if (i == 1) begin
            checks++; if (arst_out !== 1'b0) begin errors++; $display("FAIL restart_arst_clear: got %b expected 0", arst_out); end
         end
         if (i == 66) begin
            checks++; if (latch_out !== 1'b1) begin errors++; $display("FAIL restart_latch: got %b expected 1", latch_out); end
         end
         if (i == 84) begin
            checks++; if (aclk_out !== 1'b1) begin errors++; $display("FAIL restart_row_step: got %b expected 1", aclk_out); end
         end
      end
      checks++; if (early_aclk !== 0) begin errors++; $display("FAIL restart_early_aclk: got %0d expected 0", early_aclk); end
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
      brightness_in = 5'd16;
      sm_wr_en = 1'b0; sm_wr_addr = '0; sm_wr_data = '0; sm_swap_req = 1'b0;
      test_reset();
      test_frame();
      test_brightness(5'd5, 5);
      test_brightness(5'd0, 0);
      test_brightness(5'd16, 16);
      test_brightness(5'd31, 16);
      test_swap();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
